// File: rtl/bram_bist_ctrl_if.sv
// Bus between the BIST controller and the 256x32 BlockRAM macro.
// Latency: none, wires only.
// Backpressure: none; the BRAM accepts a write and a read every cycle.
interface bram_bist_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              C0, C1, C2, C3, C4, C5;

    // Controller side: drives addresses, write data and static configuration pins.
    modport master (
        output rd_addr, wr_addr, wr_data, C0, C1, C2, C3, C4, C5,
        input  rd_data
    );

    // Memory side: returns read data.
    modport slave (
        input  rd_addr, wr_addr, wr_data, C0, C1, C2, C3, C4, C5,
        output rd_data
    );
endinterface

// File: rtl/bram_bist_ctrl.sv
// BIST engine: fills the BRAM with a pattern, reads it back, compares; optional
// inverted second pass under BRAM_BIST_INVERT_PASS_EN. Latency start->done: 514+L.
// No backpressure: the BRAM writes every cycle; start is ignored unless IDLE.
module bram_bist_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int REG_BYPASS = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           pattern_sel,
    bram_bist_ctrl_if.master     bram,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_W:0]      err_count,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_data
);
    localparam int L     = (REG_BYPASS != 0) ? 1 : 2;
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SH_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_READ, S_FLUSH, S_DONE
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } cmp_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  addr_q, addr_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    cmp_t              p1_q, p1_d, p2_q, p2_d, cmp;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              pass_q, pass_d;
    logic              pat_inv;

`ifdef BRAM_BIST_INVERT_PASS_EN
    logic              pass_idx_q, pass_idx_d;
    assign pat_inv = pass_idx_q;
`else
    assign pat_inv = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] sel,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic inv);
        logic [DATA_W-1:0] p;
        p = '0;
        case (sel)
            2'd0:    for (int i = 0; i < DATA_W; i++) p[i] = a[i % ADDR_W];
            2'd1:    p = a[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
            2'd2:    p = '1;
            default: p = DATA_W'(1) << a[SH_W-1:0];
        endcase
        return inv ? ~p : p;
    endfunction

    // Static configuration: 32-bit ports, permanent write enable, read register choice.
    assign bram.C0 = 1'b1;
    assign bram.C1 = 1'b1;
    assign bram.C2 = 1'b1;
    assign bram.C3 = 1'b1;
    assign bram.C4 = 1'b1;
    assign bram.C5 = (REG_BYPASS != 0);

    assign bram.rd_addr = rd_addr_q;
    assign bram.wr_addr = wr_addr_q;
    assign bram.wr_data = wr_data_q;
    assign busy      = (state_q == S_WRITE) || (state_q == S_GAP) ||
                       (state_q == S_READ)  || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

    // Next-state, address sequencing, compare pipeline and error capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        pass_d      = pass_q;
`ifdef BRAM_BIST_INVERT_PASS_EN
        pass_idx_d  = pass_idx_q;
`endif
        // Expected word travels alongside the read so it lines up with rd_data L cycles later.
        p1_d.vld  = (state_q == S_READ);
        p1_d.addr = rd_addr_q;
        p1_d.exp  = pattern(sel_q, rd_addr_q, pat_inv);
        p2_d      = p1_q;
        cmp       = (L == 1) ? p1_q : p2_q;

        if (cmp.vld && (bram.rd_data != cmp.exp)) begin
            if (err_q == '0) begin
                fail_addr_d = cmp.addr;
                fail_data_d = bram.rd_data;
            end
            if (err_q != CNT_W'(DEPTH)) err_d = err_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: if (start) begin
                sel_d       = pattern_sel;
                err_d       = '0;
                fail_addr_d = '0;
                fail_data_d = '0;
                pass_d      = 1'b0;
`ifdef BRAM_BIST_INVERT_PASS_EN
                pass_idx_d  = 1'b0;
`endif
                wr_addr_d   = '0;
                wr_data_d   = pattern(pattern_sel, '0, 1'b0);
                addr_d      = CNT_W'(1);
                state_d     = S_WRITE;
            end
            // Word 0 is issued on entry; the MSB of addr marks all words written,
            // after which wr_* simply hold the last word so idle writes are harmless.
            S_WRITE: if (addr_q[ADDR_W]) begin
                state_d = S_GAP;
            end else begin
                wr_addr_d = addr_q[ADDR_W-1:0];
                wr_data_d = pattern(sel_q, addr_q[ADDR_W-1:0], pat_inv);
                addr_d    = addr_q + CNT_W'(1);
            end
            S_GAP: begin
                rd_addr_d = '0;
                addr_d    = CNT_W'(1);
                state_d   = S_READ;
            end
            S_READ: if (addr_q[ADDR_W]) begin
                addr_d  = '0;
                state_d = S_FLUSH;
            end else begin
                rd_addr_d = addr_q[ADDR_W-1:0];
                addr_d    = addr_q + CNT_W'(1);
            end
            S_FLUSH: if (addr_q == CNT_W'(L - 1)) begin
`ifdef BRAM_BIST_INVERT_PASS_EN
                if (!pass_idx_q) begin
                    pass_idx_d = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = pattern(sel_q, '0, 1'b1);
                    addr_d     = CNT_W'(1);
                    state_d    = S_WRITE;
                end else begin
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end
`else
                pass_d  = (err_d == '0);
                state_d = S_DONE;
`endif
            end else begin
                addr_d = addr_q + CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sel_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            pass_q      <= 1'b0;
`ifdef BRAM_BIST_INVERT_PASS_EN
            pass_idx_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            pass_q      <= pass_d;
`ifdef BRAM_BIST_INVERT_PASS_EN
            pass_idx_q  <= pass_idx_d;
`endif
        end
    end
endmodule

// File: tb/tb_bram_bist_ctrl.sv
// Bench for bram_bist_ctrl: two instances (REG_BYPASS 0 and 1), each beside a BRAM model
// with injectable read faults. Latency: n/a. Backpressure: n/a.
module tb_bram_bist_ctrl;
`ifdef BRAM_BIST_INVERT_PASS_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    typedef struct {
        int          dut;
        logic [1:0]  psel;
        int          fault;   // 0 none, 1 bit3 of word 0x10 stuck-at-0, 2 bit0 of every word flipped
        logic        pass;
        int          err;
        logic [7:0]  fa;
        logic [31:0] fd;
    } vec_t;

    typedef struct {
        int          dut;
        logic [1:0]  psel;
        int          lat;
        logic        pass;
        int          err;
        logic [7:0]  fa;
        logic [31:0] fd;
        longint      start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start [2];
    logic [1:0]  psel [2];
    int          fault [2];
    logic        busy_w [2], done_w [2], pass_w [2];
    logic [8:0]  err_w [2];
    logic [7:0]  fa_w [2], wa_w [2], ra_w [2];
    logic [31:0] fd_w [2], wd_w [2];
    logic [5:0]  cfg_w [2];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     done_cnt [2];
    int     viol [2];
    exp_t   sb [$];
    vec_t   vecs [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [1:0] s, input logic [7:0] a, input logic inv);
        logic [31:0] p;
        case (s)
            2'd0:    p = {a, a, a, a};
            2'd1:    p = a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            2'd2:    p = 32'hFFFF_FFFF;
            default: p = 32'h1 << a[4:0];
        endcase
        return inv ? ~p : p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_m
        bram_bist_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bif ();
        logic [31:0] mem [256];
        logic [31:0] r1, r2;

        bram_bist_ctrl #(.ADDR_W(8), .DATA_W(32), .REG_BYPASS(g)) dut (
            .clk(clk), .reset(reset), .start(start[g]), .pattern_sel(psel[g]),
            .bram(bif.master), .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]),
            .err_count(err_w[g]), .fail_addr(fa_w[g]), .fail_data(fd_w[g])
        );

        function automatic logic [31:0] corrupt(input logic [31:0] d, input logic [7:0] a);
            logic [31:0] r;
            r = d;
            if (fault[g] == 1 && a == 8'h10) r[3] = 1'b0;
            if (fault[g] == 2) r[0] = ~r[0];
            return r;
        endfunction

        always @(posedge clk) begin
            if (bif.C4) mem[bif.wr_addr] <= bif.wr_data;
            r1 <= corrupt(mem[bif.rd_addr], bif.rd_addr);
            r2 <= r1;
        end
        assign bif.rd_data = (g == 1) ? r1 : r2;
        assign wa_w[g]  = bif.wr_addr;
        assign wd_w[g]  = bif.wr_data;
        assign ra_w[g]  = bif.rd_addr;
        assign cfg_w[g] = {bif.C5, bif.C4, bif.C3, bif.C2, bif.C1, bif.C0};
    end

    // Scoreboard monitor: checks write/read sequencing while a test runs, pops at done.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                sb.delete();
                viol[g] = 0;
            end else begin
                if (sb.size() > 0 && sb[0].dut == g) begin
                    longint k;
                    int plen, j, p;
                    logic inv;
                    k    = cyc - sb[0].start_cyc;
                    plen = 513 + ((g == 1) ? 1 : 2);
                    if (k >= 1 && k < sb[0].lat) begin
                        j   = int'((k - 1) % plen);
                        p   = int'((k - 1) / plen);
                        inv = (p == 1);
                        if (j < 256) begin
                            if (wa_w[g] != 8'(j) || wd_w[g] != pat(sb[0].psel, 8'(j), inv)) viol[g]++;
                        end else begin
                            if (wa_w[g] != 8'hFF || wd_w[g] != pat(sb[0].psel, 8'hFF, inv)) viol[g]++;
                        end
                        if (j >= 257 && j < 513 && ra_w[g] != 8'(j - 257)) viol[g]++;
                    end
                end
                if (done_w[g]) begin
                    done_cnt[g]++;
                    check("done_expected", (sb.size() > 0 && sb[0].dut == g) ? 1 : 0, 1);
                    if (sb.size() > 0 && sb[0].dut == g) begin
                        exp_t r;
                        r = sb.pop_front();
                        check("latency", 64'(cyc - r.start_cyc), 64'(r.lat));
                        check("pass", pass_w[g], r.pass);
                        check("err_count", err_w[g], 64'(r.err));
                        check("fail_addr", fa_w[g], r.fa);
                        check("fail_data", fd_w[g], r.fd);
                        check("busy_in_done", busy_w[g], 0);
                        check("wr_rd_sequence", 64'(viol[g]), 0);
                    end
                    viol[g] = 0;
                end
            end
        end
    end

    task automatic kick(input vec_t v);
        exp_t r;
        fault[v.dut] = v.fault;
        @(negedge clk);
        psel[v.dut]  = v.psel;
        start[v.dut] = 1'b1;
        r.dut = v.dut; r.psel = v.psel; r.pass = v.pass; r.err = v.err;
        r.fa = v.fa; r.fd = v.fd; r.start_cyc = cyc;
        r.lat = NP * (513 + ((v.dut == 1) ? 1 : 2)) + 1;
        sb.push_back(r);
        @(negedge clk);
        start[v.dut] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int n0);
        for (int i = 0; i < 3000 && done_cnt[d] == n0; i++) @(negedge clk);
        check("done_timeout", (done_cnt[d] != n0) ? 1 : 0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int n0;
        n0 = done_cnt[v.dut];
        kick(v);
        wait_done(v.dut, n0);
    endtask

    initial begin
        int n0;
        longint t0;
        vecs[0] = '{dut: 0, psel: 2'd0, fault: 0, pass: 1'b1, err: 0,   fa: 8'h00, fd: 32'h0000_0000};
        vecs[1] = '{dut: 1, psel: 2'd1, fault: 0, pass: 1'b1, err: 0,   fa: 8'h00, fd: 32'h0000_0000};
        vecs[2] = '{dut: 0, psel: 2'd2, fault: 1, pass: 1'b0, err: 1,   fa: 8'h10, fd: 32'hFFFF_FFF7};
        vecs[3] = '{dut: 1, psel: 2'd3, fault: 2, pass: 1'b0, err: 256, fa: 8'h00, fd: 32'h0000_0000};
        vecs[4] = '{dut: 1, psel: 2'd2, fault: 1, pass: 1'b0, err: 1,   fa: 8'h10, fd: 32'hFFFF_FFF7};
        vecs[5] = '{dut: 0, psel: 2'd3, fault: 2, pass: 1'b0, err: 256, fa: 8'h00, fd: 32'h0000_0000};
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; psel[g] = 2'd0; fault[g] = 0; done_cnt[g] = 0; viol[g] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_busy", busy_w[g], 0);
            check("rst_done", done_w[g], 0);
            check("rst_pass", pass_w[g], 0);
            check("rst_err", err_w[g], 0);
            check("rst_fail_addr", fa_w[g], 0);
            check("rst_fail_data", fd_w[g], 0);
            check("rst_wr_addr", wa_w[g], 0);
            check("rst_wr_data", wd_w[g], 0);
            check("rst_rd_addr", ra_w[g], 0);
            check("cfg_pins", cfg_w[g], {g[0], 5'b11111});
        end
        reset = 1'b0;
        @(negedge clk);

        // Table-driven runs
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            if (i == 0) check("mem_0x37", g_m[0].mem[8'h37], (NP == 2) ? 32'hC8C8_C8C8 : 32'h3737_3737);
            if (i == 1) check("mem_0x01", g_m[1].mem[8'h01], (NP == 2) ? 32'hAAAA_AAAA : 32'h5555_5555);
            repeat (3) @(negedge clk);
        end

        // Reset 100 cycles into WRITE aborts without a done pulse
        n0 = done_cnt[0];
        kick(vecs[0]);
        t0 = sb[0].start_cyc;
        while (cyc < t0 + 100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_w[0], 0);
        check("abort_wr_addr", wa_w[0], 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (600) @(negedge clk);
        check("abort_no_done", 64'(done_cnt[0]), 64'(n0));
        run_vec(vecs[0]);

        // start during READ and in the DONE cycle are both ignored
        n0 = done_cnt[0];
        kick(vecs[0]);
        t0 = sb[0].start_cyc;
        while (cyc < t0 + 300) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 3000 && !done_w[0]; i++) @(negedge clk);
        check("saw_done", done_w[0], 1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("busy_after_done", busy_w[0], 0);
        repeat (600) @(negedge clk);
        check("single_done", 64'(done_cnt[0]), 64'(n0 + 1));
        check("idle_busy", busy_w[0], 0);
        check("pass_held", pass_w[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
